// File: rtl/qbert_only_switch_debounce.sv
// qbert_only_switch_debounce
//   Conditions raw slide switches for the qbert_only switch PIO: two-flop
//   synchronizer per bit, per-bit stability counter debounce, and one-cycle
//   rise/fall pulses on every accepted level change.
//
// Parameters:
//   WIDTH         number of switch bits (PIO in_port width)
//   STABLE_CYCLES consecutive differing samples needed to accept a change (>= 2)
//   CNT_W         counter width, 2**CNT_W > STABLE_CYCLES-1
//   RESET_VALUE   synchronizer / sw_clean value while in reset
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   sw_raw    raw switch pins, asynchronous to clk
//   sw_clean  debounced level, registered, drives PIO in_port
//   sw_rise   one-cycle pulse on a sw_clean 0->1 transition
//   sw_fall   one-cycle pulse on a sw_clean 1->0 transition
module qbert_only_switch_debounce #(
  parameter int unsigned      WIDTH         = 4,
  parameter int unsigned      STABLE_CYCLES = 500000,
  parameter int unsigned      CNT_W         = 19,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= RESET_VALUE;
      sync2    <= RESET_VALUE;
      sw_clean <= RESET_VALUE;
      sw_rise  <= '0;
      sw_fall  <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= sw_raw;
      sync2   <= sync1;
      // Pulses default low; only the accepting bit raises one below.
      sw_rise <= '0;
      sw_fall <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2[i] == sw_clean[i]) begin
          // Any sample agreeing with the current level restarts the count.
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          sw_clean[i] <= sync2[i];
          cnt[i]      <= '0;
          sw_rise[i]  <= sync2[i];
          sw_fall[i]  <= ~sync2[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_qbert_only_switch_debounce.sv
// tb_qbert_only_switch_debounce
//   Directed bench for qbert_only_switch_debounce with STABLE_CYCLES=8,
//   WIDTH=4, RESET_VALUE=0. Inputs change 1 time unit after a rising edge;
//   the first edge after a change is E0, so raw->clean takes 10 edge waits
//   (E0..E0+9). Outputs are sampled 1 time unit after the edge.
module tb_qbert_only_switch_debounce;

  logic       clk;
  logic       reset_n;
  logic [3:0] sw_raw;
  logic [3:0] sw_clean;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;

  int checks = 0;
  int errors = 0;

  qbert_only_switch_debounce #(
    .WIDTH        (4),
    .STABLE_CYCLES(8),
    .CNT_W        (4),
    .RESET_VALUE  (4'h0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sw_raw  (sw_raw),
    .sw_clean(sw_clean),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    sw_raw  = 4'h0;
    #1;
    check("por_clean", sw_clean, 4'h0);
    check("por_rise",  sw_rise,  4'h0);
    check("por_fall",  sw_fall,  4'h0);
    tick(3);
    reset_n = 1'b1;
    tick(3);
    check("idle_clean", sw_clean, 4'h0);

    // Clean step on bit 0
    sw_raw = 4'h1;
    tick(9);
    check("step_e8_clean", sw_clean, 4'h0);
    check("step_e8_rise",  sw_rise,  4'h0);
    tick(1);
    check("step_e9_clean", sw_clean, 4'h1);
    check("step_e9_rise",  sw_rise,  4'h1);
    check("step_e9_fall",  sw_fall,  4'h0);
    tick(1);
    check("step_e10_rise", sw_rise,  4'h0);
    check("step_e10_clean", sw_clean, 4'h1);

    // Bounce on bit 1: high 5, low 2, then high
    sw_raw = 4'h3;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("bounce_hi_rise", sw_rise, 4'h0);
    end
    sw_raw = 4'h1;
    for (int k = 0; k < 2; k++) begin
      tick(1);
      check("bounce_lo_rise", sw_rise, 4'h0);
    end
    sw_raw = 4'h3;
    tick(9);
    check("bounce_e8_clean", sw_clean, 4'h1);
    check("bounce_e8_rise",  sw_rise,  4'h0);
    tick(1);
    check("bounce_e9_clean", sw_clean, 4'h3);
    check("bounce_e9_rise",  sw_rise,  4'h2);
    tick(1);
    check("bounce_e10_rise", sw_rise, 4'h0);

    // Bring bit 2 high, then release it for 12 cycles
    sw_raw = 4'h7;
    tick(12);
    check("rel_pre_clean", sw_clean, 4'h7);
    sw_raw = 4'h3;
    tick(9);
    check("rel_e8_clean", sw_clean, 4'h7);
    check("rel_e8_fall",  sw_fall,  4'h0);
    tick(1);
    check("rel_e9_clean", sw_clean, 4'h3);
    check("rel_e9_fall",  sw_fall,  4'h4);
    check("rel_e9_rise",  sw_rise,  4'h0);
    tick(1);
    check("rel_e10_fall", sw_fall, 4'h0);
    check("rel_e10_rise", sw_rise, 4'h0);
    tick(1);

    // Simultaneous bits: 0 -> A
    sw_raw = 4'h0;
    tick(12);
    check("sim_pre_clean", sw_clean, 4'h0);
    sw_raw = 4'hA;
    tick(9);
    check("sim_e8_clean", sw_clean, 4'h0);
    tick(1);
    check("sim_e9_clean", sw_clean, 4'hA);
    check("sim_e9_rise",  sw_rise,  4'hA);
    check("sim_e9_fall",  sw_fall,  4'h0);
    tick(1);
    check("sim_e10_rise", sw_rise, 4'h0);

    // Reset in the middle of a bit 3 count
    sw_raw = 4'h0;
    tick(12);
    check("rmid_pre_clean", sw_clean, 4'h0);
    sw_raw = 4'h8;
    tick(5);
    reset_n = 1'b0;
    #1;
    check("rmid_rst_clean", sw_clean, 4'h0);
    check("rmid_rst_rise",  sw_rise,  4'h0);
    tick(2);
    reset_n = 1'b1;
    tick(9);
    check("rmid_e8_clean", sw_clean, 4'h0);
    check("rmid_e8_rise",  sw_rise,  4'h0);
    tick(1);
    check("rmid_e9_clean", sw_clean, 4'h8);
    check("rmid_e9_rise",  sw_rise,  4'h8);
    tick(1);
    check("rmid_e10_rise", sw_rise, 4'h0);
    check("rmid_e10_clean", sw_clean, 4'h8);

    // Asynchronous reset with all switches high, between clock edges
    sw_raw = 4'hF;
    tick(12);
    check("async_pre_clean", sw_clean, 4'hF);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_clean", sw_clean, 4'h0);
    check("async_rise",  sw_rise,  4'h0);
    check("async_fall",  sw_fall,  4'h0);
    tick(2);
    check("async_hold_clean", sw_clean, 4'h0);
    reset_n = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
